// File: rtl/debug_host_link_if.sv
// debug_host_link_if: bundles the command, UART handshake and reply signals of debug_host_link.
//   master : view of the host link itself (takes commands and rx bytes, drives tx and replies)
//   slave  : view of the surrounding test top / UART wrapper
// Signals:
//   cmd_valid/cmd_byte/reply_words/cmd_ready    command request and acceptance
//   uart_tx_ready/uart_tx_data/uart_tx_done     transmitter start pulse, byte, completion
//   uart_rx_ready/uart_rx_data                  receiver byte valid level and byte
//   word_valid/word_data/word_index             assembled reply word pulse, value, index
//   done/timeout                                end-of-transaction pulses
//   state                                       FSM state for observation
interface debug_host_link_if #(
  parameter int unsigned NB        = 32,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CNT_W     = 8
);
  logic                 cmd_valid;
  logic [DATA_BITS-1:0] cmd_byte;
  logic [CNT_W-1:0]     reply_words;
  logic                 cmd_ready;
  logic                 uart_tx_ready;
  logic [DATA_BITS-1:0] uart_tx_data;
  logic                 uart_tx_done;
  logic                 uart_rx_ready;
  logic [DATA_BITS-1:0] uart_rx_data;
  logic                 word_valid;
  logic [NB-1:0]        word_data;
  logic [CNT_W-1:0]     word_index;
  logic                 done;
  logic                 timeout;
  logic [2:0]           state;

  modport master (
    input  cmd_valid, cmd_byte, reply_words, uart_tx_done, uart_rx_ready, uart_rx_data,
    output cmd_ready, uart_tx_ready, uart_tx_data, word_valid, word_data, word_index,
           done, timeout, state
  );

  modport slave (
    output cmd_valid, cmd_byte, reply_words, uart_tx_done, uart_rx_ready, uart_rx_data,
    input  cmd_ready, uart_tx_ready, uart_tx_data, word_valid, word_data, word_index,
           done, timeout, state
  );
endinterface

// File: rtl/debug_host_link.sv
// debug_host_link: host-side initiator for the UART debug protocol.
// Sends one command byte through the UART transmitter handshake, then collects a requested
// number of reply words from the UART receiver, bytes arriving LSB first.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous reset, active-high
//   bus      debug_host_link_if.master (command, UART tx/rx, reply words, status pulses)
module debug_host_link #(
  parameter int unsigned NB             = 32,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  debug_host_link_if.master bus
);

  localparam int unsigned BPW = NB / DATA_BITS;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BCW-1:0] ByteLast = BCW'(BPW - 1);
  localparam logic [TW-1:0]  TmoLast  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSend   = 3'd1,
    StWaitTx = 3'd2,
    StRecv   = 3'd3,
    StDone   = 3'd4,
    StError  = 3'd5
  } state_e;

  state_e               state_q;
  logic                 cmd_ready_q;
  logic                 tx_start_q;
  logic [DATA_BITS-1:0] tx_data_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     word_cnt_q;
  logic [BCW-1:0]       byte_cnt_q;
  logic [TW-1:0]        tmo_q;
  logic [NB-1:0]        shift_q;
  logic                 rx_prev_q;
  logic                 word_valid_q;
  logic [NB-1:0]        word_data_q;
  logic [CNT_W-1:0]     word_index_q;
  logic                 done_q;
  logic                 timeout_q;

  logic          rx_edge;
  logic [NB-1:0] word_next;

  // Only a rising edge of the receiver valid counts as a new byte.
  assign rx_edge   = bus.uart_rx_ready & ~rx_prev_q;
  assign word_next = {bus.uart_rx_data, shift_q[NB-1:DATA_BITS]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= StIdle;
      cmd_ready_q  <= 1'b1;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      count_q      <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      tmo_q        <= '0;
      shift_q      <= '0;
      rx_prev_q    <= 1'b0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_index_q <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      rx_prev_q    <= bus.uart_rx_ready;
      tx_start_q   <= 1'b0;
      word_valid_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            // tx_data_q doubles as the latched command byte; the start pulse
            // is high exactly while the FSM sits in StSend.
            tx_data_q   <= bus.cmd_byte;
            count_q     <= bus.reply_words;
            word_cnt_q  <= '0;
            cmd_ready_q <= 1'b0;
            tx_start_q  <= 1'b1;
            state_q     <= StSend;
          end
        end

        StSend: begin
          tmo_q   <= '0;
          state_q <= StWaitTx;
        end

        StWaitTx: begin
          if (bus.uart_tx_done) begin
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            if (count_q == '0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StRecv;
            end
          end else if (tmo_q == TmoLast) begin
            timeout_q <= 1'b1;
            state_q   <= StError;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        StRecv: begin
          // An accepted byte takes priority over a coincident timeout.
          if (rx_edge) begin
            shift_q <= word_next;
            tmo_q   <= '0;
            if (byte_cnt_q == ByteLast) begin
              byte_cnt_q   <= '0;
              word_data_q  <= word_next;
              word_valid_q <= 1'b1;
              word_index_q <= word_cnt_q;
              word_cnt_q   <= word_cnt_q + CNT_W'(1);
              if ((word_cnt_q + CNT_W'(1)) == count_q) begin
                done_q  <= 1'b1;
                state_q <= StDone;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + BCW'(1);
            end
          end else if (tmo_q == TmoLast) begin
            // Drop any partially assembled word.
            byte_cnt_q <= '0;
            shift_q    <= '0;
            timeout_q  <= 1'b1;
            state_q    <= StError;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        StDone, StError: begin
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end

        default: begin
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.uart_tx_ready = tx_start_q;
  assign bus.uart_tx_data  = tx_data_q;
  assign bus.word_valid    = word_valid_q;
  assign bus.word_data     = word_data_q;
  assign bus.word_index    = word_index_q;
  assign bus.done          = done_q;
  assign bus.timeout       = timeout_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_debug_host_link.sv
// tb_debug_host_link: scoreboard bench for debug_host_link (TIMEOUT_CYCLES = 100).
// Expected tx bytes and reply words are queued when stimulus is driven and compared by a
// monitor when the DUT pulses uart_tx_ready / word_valid.
module tb_debug_host_link;

  localparam int unsigned Tmo = 100;

  logic clk;
  logic reset;

  debug_host_link_if #(.NB(32), .DATA_BITS(8), .CNT_W(8)) bus ();

  debug_host_link #(
    .NB(32),
    .DATA_BITS(8),
    .CNT_W(8),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_tx = 0;
  int n_words = 0;
  int n_done = 0;
  int n_tmo = 0;

  logic [7:0]  exp_tx_q[$];
  logic [31:0] exp_word_q[$];
  logic [7:0]  exp_idx_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.uart_tx_ready) begin
        n_tx++;
        if (exp_tx_q.size() == 0) check_eq("tx_unexpected", 64'd1, 64'd0);
        else check_eq("tx_data", 64'(bus.uart_tx_data), 64'(exp_tx_q.pop_front()));
      end
      if (bus.word_valid) begin
        n_words++;
        if (exp_word_q.size() == 0) begin
          check_eq("word_unexpected", 64'd1, 64'd0);
        end else begin
          check_eq("word_data", 64'(bus.word_data), 64'(exp_word_q.pop_front()));
          check_eq("word_index", 64'(bus.word_index), 64'(exp_idx_q.pop_front()));
        end
      end
      if (bus.done) n_done++;
      if (bus.timeout) n_tmo++;
    end
  end

  task automatic send_cmd(input logic [7:0] cmd, input logic [7:0] words);
    int k = 0;
    while (!bus.cmd_ready && k < 50) begin
      tick(1);
      k++;
    end
    check_eq("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    exp_tx_q.push_back(cmd);
    bus.cmd_valid   = 1'b1;
    bus.cmd_byte    = cmd;
    bus.reply_words = words;
    tick(1);
    bus.cmd_valid = 1'b0;
    tick(2);
  endtask

  task automatic pulse_tx_done();
    bus.uart_tx_done = 1'b1;
    tick(1);
    bus.uart_tx_done = 1'b0;
  endtask

  task automatic send_byte_hold(input logic [7:0] b, input int hold);
    bus.uart_rx_data  = b;
    bus.uart_rx_ready = 1'b1;
    tick(hold);
    bus.uart_rx_ready = 1'b0;
    tick(1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [7:0] idx);
    exp_word_q.push_back(w);
    exp_idx_q.push_back(idx);
    for (int i = 0; i < 4; i++) send_byte_hold(w[8*i +: 8], 1);
  endtask

  task automatic wait_done(input int base);
    int k = 0;
    while (n_done == base && k < 200) begin
      tick(1);
      k++;
    end
    check_eq("done_seen", 64'(n_done), 64'(base + 1));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    check_eq({tag, "_state"}, 64'(bus.state), 64'd0);
    check_eq({tag, "_tx_ready"}, 64'(bus.uart_tx_ready), 64'd0);
    check_eq({tag, "_tx_data"}, 64'(bus.uart_tx_data), 64'd0);
    check_eq({tag, "_word_valid"}, 64'(bus.word_valid), 64'd0);
    check_eq({tag, "_word_data"}, 64'(bus.word_data), 64'd0);
    check_eq({tag, "_word_index"}, 64'(bus.word_index), 64'd0);
    check_eq({tag, "_done"}, 64'(bus.done), 64'd0);
    check_eq({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_tx, b_w, b_d, b_t, k;
    reset             = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_byte      = '0;
    bus.reply_words   = '0;
    bus.uart_tx_done  = 1'b0;
    bus.uart_rx_ready = 1'b0;
    bus.uart_rx_data  = '0;

    // 1. Reset values.
    tick(3);
    check_reset_values("reset");
    reset = 1'b0;
    tick(2);

    // 2. Command with no reply words.
    b_tx = n_tx; b_w = n_words; b_d = n_done;
    send_cmd(8'h50, 8'd0);
    check_eq("t2_state_wait_tx", 64'(bus.state), 64'd2);
    pulse_tx_done();
    wait_done(b_d);
    check_eq("t2_tx_pulses", 64'(n_tx - b_tx), 64'd1);
    check_eq("t2_no_words", 64'(n_words - b_w), 64'd0);
    tick(2);
    check_eq("t2_idle_ready", 64'(bus.cmd_ready), 64'd1);

    // 3. Two reply words; a byte before RECV is dropped, cmd_valid in RECV is ignored.
    b_tx = n_tx; b_w = n_words; b_d = n_done;
    send_cmd(8'h52, 8'd2);
    send_byte_hold(8'hAA, 1);
    pulse_tx_done();
    send_word(32'h1234_5678, 8'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = 8'h77;
    tick(1);
    bus.cmd_valid = 1'b0;
    send_word(32'hDEAD_BEEF, 8'd1);
    wait_done(b_d);
    check_eq("t3_words", 64'(n_words - b_w), 64'd2);
    tick(10);
    check_eq("t3_tx_not_queued", 64'(n_tx - b_tx), 64'd1);
    check_eq("t3_word_held", 64'(bus.word_data), 64'hDEAD_BEEF);

    // 4. rx_ready held high for 3 cycles counts as a single byte.
    b_w = n_words; b_d = n_done;
    send_cmd(8'h53, 8'd1);
    pulse_tx_done();
    send_byte_hold(8'h11, 3);
    send_byte_hold(8'h22, 1);
    send_byte_hold(8'h33, 1);
    check_eq("t4_no_early_word", 64'(n_words - b_w), 64'd0);
    exp_word_q.push_back(32'h4433_2211);
    exp_idx_q.push_back(8'd0);
    send_byte_hold(8'h44, 1);
    wait_done(b_d);
    check_eq("t4_words", 64'(n_words - b_w), 64'd1);

    // 5. Timeout after two bytes of a one-word reply.
    b_w = n_words; b_d = n_done; b_t = n_tmo;
    send_cmd(8'h54, 8'd1);
    pulse_tx_done();
    send_byte_hold(8'h01, 1);
    bus.uart_rx_data  = 8'h02;
    bus.uart_rx_ready = 1'b1;
    tick(1);  // byte accepted on this edge
    bus.uart_rx_ready = 1'b0;
    k = 0;
    while (!bus.timeout && k < 300) begin
      tick(1);
      k++;
    end
    check_eq("t5_timeout_latency", 64'(k), 64'(Tmo));
    tick(2);
    check_eq("t5_timeout_pulses", 64'(n_tmo - b_t), 64'd1);
    check_eq("t5_no_words", 64'(n_words - b_w), 64'd0);
    check_eq("t5_no_done", 64'(n_done - b_d), 64'd0);
    check_eq("t5_ready_again", 64'(bus.cmd_ready), 64'd1);

    // 5b. Next transaction starts from a clean byte counter.
    b_d = n_done;
    send_cmd(8'h55, 8'd1);
    pulse_tx_done();
    send_word(32'hDDCC_BBAA, 8'd0);
    wait_done(b_d);

    // 6. Reset in the middle of a reply, then a fresh transaction.
    b_w = n_words; b_d = n_done; b_t = n_tmo;
    send_cmd(8'h56, 8'd2);
    pulse_tx_done();
    send_byte_hold(8'h99, 1);
    send_byte_hold(8'h98, 1);
    reset = 1'b1;
    tick(2);
    check_reset_values("midreset");
    reset = 1'b0;
    tick(1);
    check_eq("t6_no_words", 64'(n_words - b_w), 64'd0);
    check_eq("t6_no_done", 64'(n_done - b_d), 64'd0);
    check_eq("t6_no_timeout", 64'(n_tmo - b_t), 64'd0);
    exp_tx_q.delete();
    send_cmd(8'h57, 8'd1);
    pulse_tx_done();
    send_word(32'h0000_0001, 8'd0);
    wait_done(b_d);

    tick(3);
    check_eq("sb_words_drained", 64'(exp_word_q.size()), 64'd0);
    check_eq("sb_tx_drained", 64'(exp_tx_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
